axi2mem_tcdm_synch_fork: RTL
============================

// Module: axi2mem_tcdm_synch_fork
// PURPOSE
//  Fork side of the axi2mem TCDM synch handshake: accepts one synch token (req + ID) and delivers it
//  to two independent consumers (branch 0 = read path, branch 1 = write path).
//  Each branch buffers tokens in its own FIFO and drains at its own pace.
//  Upstream is granted only when both branches can accept, so both branches see every token in the same order.
// PARAMETERS
//  ID_WIDTH  6  width of synch ID
//  DEPTH     4  entries per branch FIFO; power of two, >=2; must equal cmd queue depth
// PORTS
//  clk_i        in   1              clock
//  rst_ni       in   1              asynchronous active-low reset
//  test_en_i    in   1              test mode (clock-gate bypass only; no functional effect)
//  synch_req_i  in   1              upstream token valid
//  synch_id_i   in   ID_WIDTH       upstream token ID
//  synch_gnt_o  out  1              upstream grant; transfer = synch_req_i & synch_gnt_o
//  synch_req_o  out  [1:0]          per-branch token valid (branch FIFO not empty)
//  synch_id_o   out  [1:0][ID_W]    per-branch head-of-FIFO ID
//  synch_gnt_i  in   [1:0]          per-branch consumer grant; pop = synch_req_o[i] & synch_gnt_i[i]
//  err_o        out  1              sticky protocol error (see CONFIGURATION)
// BEHAVIOUR
//  Reset (async, rst_ni=0): both FIFOs empty, pointers/counters 0; synch_req_o=2'b00, synch_gnt_o=1,
//   synch_id_o=0, err_o=0. Reset mid-operation discards all buffered tokens immediately.
//  synch_gnt_o = ~full[0] & ~full[1]; combinational from state only, never from synch_req_i or synch_gnt_i.
//  Push: on transfer, synch_id_i is written into BOTH FIFOs in the same cycle.
//  No fall-through: a token pushed in cycle N appears on synch_req_o/synch_id_o in cycle N+1 at the earliest.
//  Pop: independent per branch; head advances on the cycle after the pop handshake.
//  Simultaneous push+pop on a branch: count unchanged, both pointers advance.
//  Full branch: gnt_o=0 even if that branch pops this cycle (no same-cycle space reuse).
//  Empty branch: synch_req_o[i]=0; synch_gnt_i[i] is ignored for state.
//  Per-branch count: $clog2(DEPTH)+1 bits; pointers $clog2(DEPTH) bits and wrap modulo DEPTH.
//  Ordering: each branch outputs IDs in exact push order.
//  Branch skew is bounded by DEPTH tokens.
//  synch_id_o[i] holds stable while synch_req_o[i]=1 and not popped.
// CONFIGURATION
//  Macro AXI2MEM_TCDM_SYNCH_FORK_CHECK_EN:
//   defined: err_o is set one cycle after either of:
//    - synch_gnt_i[i]=1 while synch_req_o[i]=0;
//    - synch_req_i dropped, or synch_id_i changed, while the previous cycle had synch_req_i=1 & synch_gnt_o=0.
//   err_o clears only on reset.
//   undefined: err_o tied 0; no checker logic synthesised.
// STRUCTURE
//  Package axi2mem_tcdm_pkg: SYNCH_ID_WIDTH=6, SYNCH_DEPTH=4 localparams; typedef synch_id_t (logic [5:0]).
//  Sub-module axi2mem_tcdm_synch_fork_branch: one FIFO.
//   Ports: push, data, pop, full, empty, head; holds ptrs and count.
//   Instantiated twice via generate; top holds the grant AND and the optional checker.
// TESTING
//  1 Reset, then push ID 0x05 with both gnt_i=1:
//    req_o=2'b11, id_o={0x05,0x05} next cycle; both pop, req_o=00 after.
//  2 Branch1 gnt_i=0, push 0x01..0x04:
//    after 4th push gnt_o=0; branch0 drains 01,02,03,04; gnt_o stays 0 until branch1 pops once.
//  3 Both branches full, branch1 pops while req_i=1:
//    gnt_o=0 that cycle, =1 next; no token lost or duplicated.
//  4 Random gnt_i on both branches, 1000 tokens with incrementing IDs:
//    each branch sees 0..999 mod 64 in order; skew never exceeds 4.
//  5 Assert rst_ni with 3 tokens buffered:
//    req_o=00 and gnt_o=1 asynchronously; next push 0x2A is the only token seen.
//  6 With CHECK_EN defined, gnt_i[0]=1 while branch0 is empty:
//    err_o=1 next cycle and held. Without the macro, err_o=0.

Source files
------------

// File: rtl/axi2mem_tcdm_pkg.sv
// Shared types and default sizing for the axi2mem TCDM synch fork.
package axi2mem_tcdm_pkg;

    localparam int unsigned SYNCH_ID_WIDTH = 6;
    localparam int unsigned SYNCH_DEPTH    = 4;

    typedef logic [SYNCH_ID_WIDTH-1:0] synch_id_t;

endpackage : axi2mem_tcdm_pkg

// File: rtl/axi2mem_tcdm_synch_fork_branch.sv
// One branch FIFO of the synch fork: no fall-through, registered head,
// pointers wrap modulo DEPTH (DEPTH is a power of two).
module axi2mem_tcdm_synch_fork_branch
    import axi2mem_tcdm_pkg::*;
#(
    parameter int unsigned WIDTH = SYNCH_ID_WIDTH,
    parameter int unsigned DEPTH = SYNCH_DEPTH
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push,
    input  logic [WIDTH-1:0] data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic [WIDTH-1:0] mem_r [DEPTH];
    logic             push_s;
    logic             pop_s;

    // Qualify requests so a full FIFO never overwrites and an empty one never underflows.
    always_comb begin
        push_s = push & ~full;
        pop_s  = pop & ~empty;
    end

    // Storage, pointers and occupancy; reset discards every buffered token.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= data;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign full  = (count_r == CNT_W'(DEPTH));
    assign empty = (count_r == CNT_W'(0));
    assign head  = mem_r[rd_ptr_r];

endmodule : axi2mem_tcdm_synch_fork_branch

// File: rtl/axi2mem_tcdm_synch_fork.sv
// Fork of the axi2mem TCDM synch handshake: each accepted token is copied
// into a read-path and a write-path FIFO that drain independently.
// Optional protocol checker enabled by macro AXI2MEM_TCDM_SYNCH_FORK_CHECK_EN.
module axi2mem_tcdm_synch_fork
    import axi2mem_tcdm_pkg::*;
#(
    parameter int unsigned ID_WIDTH = SYNCH_ID_WIDTH,
    parameter int unsigned DEPTH    = SYNCH_DEPTH
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     test_en_i,
    input  logic                     synch_req_i,
    input  logic [ID_WIDTH-1:0]      synch_id_i,
    output logic                     synch_gnt_o,
    output logic [1:0]               synch_req_o,
    output logic [1:0][ID_WIDTH-1:0] synch_id_o,
    input  logic [1:0]               synch_gnt_i,
    output logic                     err_o
);

    logic [1:0] full_s;
    logic [1:0] empty_s;
    logic [1:0] pop_s;
    logic       push_s;
    logic       unused_test_en_s;

    // Test mode only bypasses clock gating elsewhere; nothing to do here.
    assign unused_test_en_s = test_en_i;

    // Grant depends on FIFO state only, so both branches always take the token together.
    always_comb begin
        synch_gnt_o = ~full_s[0] & ~full_s[1];
        push_s      = synch_req_i & synch_gnt_o;
    end

    for (genvar i = 0; i < 2; i++) begin : g_branch
        assign synch_req_o[i] = ~empty_s[i];
        assign pop_s[i]       = synch_req_o[i] & synch_gnt_i[i];

        axi2mem_tcdm_synch_fork_branch #(
            .WIDTH (ID_WIDTH),
            .DEPTH (DEPTH)
        ) i_branch (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .push   (push_s),
            .data   (synch_id_i),
            .pop    (pop_s[i]),
            .full   (full_s[i]),
            .empty  (empty_s[i]),
            .head   (synch_id_o[i])
        );
    end

`ifdef AXI2MEM_TCDM_SYNCH_FORK_CHECK_EN
    logic                err_r;
    logic                stall_r;
    logic [ID_WIDTH-1:0] stall_id_r;
    logic                err_set_s;

    // Flag a grant on an empty branch, or an upstream request withdrawn/altered while stalled.
    always_comb begin
        err_set_s = (|(synch_gnt_i & ~synch_req_o)) |
                    (stall_r & (~synch_req_i | (synch_id_i != stall_id_r)));
    end

    // Remember last cycle's stall and make the error sticky until reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_r      <= 1'b0;
            stall_r    <= 1'b0;
            stall_id_r <= '0;
        end else begin
            stall_r    <= synch_req_i & ~synch_gnt_o;
            stall_id_r <= synch_id_i;
            if (err_set_s) begin
                err_r <= 1'b1;
            end else begin
                err_r <= err_r;
            end
        end
    end

    assign err_o = err_r;
`else
    assign err_o = 1'b0;
`endif

endmodule : axi2mem_tcdm_synch_fork
